// File: rtl/gpu_term_pkg.sv
// Shared definitions for the terminal renderer: cell layout, ANSI bytes, FSM states.
package gpu_term_pkg;

    // Cell field positions
    localparam int unsigned BOLD_BIT = 15;
    localparam int unsigned UL_BIT   = 14;
    localparam int unsigned FG_MSB   = 13;
    localparam int unsigned FG_LSB   = 11;
    localparam int unsigned BG_MSB   = 10;
    localparam int unsigned BG_LSB   = 8;

    // ANSI bytes
    localparam logic [7:0] ESC     = 8'h1B;
    localparam logic [7:0] LBR     = 8'h5B;
    localparam logic [7:0] SEMI    = 8'h3B;
    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] CH_H    = 8'h48;
    localparam logic [7:0] CH_m    = 8'h6D;
    localparam logic [7:0] CH_J    = 8'h4A;
    localparam logic [7:0] CH_l    = 8'h6C;
    localparam logic [7:0] CH_Q    = 8'h3F;
    localparam logic [7:0] CH_SP   = 8'h20;

    typedef enum logic [3:0] {
        StInit, StIdle, StLock, StHide, StClear, StRead, StLoad, StCmp,
        StWshadow, StCup, StSgr, StChar, StNext, StDone
    } state_e;

    // Byte handshake phases
    typedef enum logic [1:0] {PhWait, PhSend, PhGap} tx_ph_e;

    // Constant conversion of a parameter (0..999) to three BCD digits
    function automatic logic [11:0] to_bcd3(input int unsigned v);
        to_bcd3 = {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/bcd_counter3.sv
// Three-digit BCD counter: loads its offset or increments by one.
module bcd_counter3 import gpu_term_pkg::*; #(
    parameter int unsigned Offset = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        inc_i,
    output logic [11:0] digits_o
);

    localparam logic [11:0] OffsetBcd = to_bcd3(Offset);

    logic [11:0] digits_q, digits_d;

    // Next value: load wins over increment, decimal carry between digits
    always_comb begin
        digits_d = digits_q;
        if (load_i) begin
            digits_d = OffsetBcd;
        end else if (inc_i) begin
            if (digits_q[3:0] != 4'd9) begin
                digits_d[3:0] = digits_q[3:0] + 4'd1;
            end else begin
                digits_d[3:0] = 4'd0;
                if (digits_q[7:4] != 4'd9) begin
                    digits_d[7:4] = digits_q[7:4] + 4'd1;
                end else begin
                    digits_d[7:4]  = 4'd0;
                    digits_d[11:8] = (digits_q[11:8] == 4'd9) ? 4'd0 : digits_q[11:8] + 4'd1;
                end
            end
        end
    end

    // Digit register
    always_ff @(posedge clk_i) begin
        if (rst_i) digits_q <= OffsetBcd;
        else       digits_q <= digits_d;
    end

    assign digits_o = digits_q;

endmodule

// File: rtl/gpu_term_renderer.sv
// Diffs master VRAM against a shadow copy and streams ANSI updates to a byte transmitter.
module gpu_term_renderer import gpu_term_pkg::*; #(
    parameter int unsigned COLS     = 64,
    parameter int unsigned ROWS     = 16,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned OFFSET_X = 9,
    parameter int unsigned OFFSET_Y = 5
) (
    input  logic              CLK,
    input  logic              RESET,
    output logic              VRAM_ENABLE,
    output logic [ADDR_W-1:0] VRAM_ADDR,
    input  logic [15:0]       VRAM_DATA_R,
    output logic              VRAM_LOCK,
    output logic              SIG_READY,
    input  logic              SIG_DRAW,
    input  logic              SIG_FORCE,
    output logic [7:0]        TX_DATA,
    output logic              TX_SEND,
    input  logic              TX_READY
);

    localparam int unsigned       ColW     = $clog2(COLS);
    localparam logic [ColW-1:0]   ColMax   = '1;
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);

    state_e            state_q, state_d;
    tx_ph_e            ph_q, ph_d;
    logic [3:0]        idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d, addr_last_q, addr_last_d;
    logic [15:0]       cell_q, cell_d;
    logic [7:0]        attr_q, attr_d;
    logic              attr_valid_q, attr_valid_d, run_valid_q, run_valid_d;
    logic              force_pend_q, force_pend_d, force_act_q, force_act_d;

    logic [15:0] shadow_mem [2**ADDR_W];
    logic [15:0] shadow_rdata;
    logic        shadow_we, shadow_re, vram_en, tx_send, emit_done, vram_lock;
    logic        cnt_load, col_load, col_inc, row_inc, cup_needed, sgr_needed;
    logic [11:0] row_bcd, col_bcd;
    logic [7:0]  seq [16];
    logic [3:0]  seq_len;

    bcd_counter3 #(.Offset(OFFSET_Y)) u_row (
        .clk_i(CLK), .rst_i(RESET), .load_i(cnt_load), .inc_i(row_inc), .digits_o(row_bcd)
    );
    bcd_counter3 #(.Offset(OFFSET_X)) u_col (
        .clk_i(CLK), .rst_i(RESET), .load_i(cnt_load | col_load), .inc_i(col_inc),
        .digits_o(col_bcd)
    );

    // Shadow VRAM: one-cycle read latency
    always_ff @(posedge CLK) begin
        if (shadow_we) shadow_mem[addr_q] <= cell_q;
        if (shadow_re) shadow_rdata <= shadow_mem[addr_q];
    end

    // CUP can be dropped only when this cell directly follows the last one printed on its row
    assign cup_needed = !(run_valid_q && (addr_q == addr_last_q + AddrOne)
                          && (addr_q[ColW-1:0] != '0));
    assign sgr_needed = !(attr_valid_q && (cell_q[15:8] == attr_q));

    // Byte sequence for the current emitting state; seq_len counts the bytes
    always_comb begin
        for (int i = 0; i < 16; i++) seq[i] = 8'h00;
        seq_len = 4'd0;
        case (state_q)
            StHide: begin
                seq[0] = ESC; seq[1] = LBR; seq[2] = CH_Q; seq[3] = ASCII_0 | 8'd2;
                seq[4] = ASCII_0 | 8'd5; seq[5] = CH_l; seq_len = 4'd6;
            end
            StClear: begin
                seq[0] = ESC; seq[1] = LBR; seq[2] = ASCII_0 | 8'd3; seq[3] = ASCII_0 | 8'd7;
                seq[4] = SEMI; seq[5] = ASCII_0 | 8'd4; seq[6] = ASCII_0; seq[7] = CH_m;
                seq[8] = ESC; seq[9] = LBR; seq[10] = ASCII_0 | 8'd2; seq[11] = CH_J;
                seq_len = 4'd12;
            end
            StCup: begin
                seq[seq_len] = ESC; seq_len = seq_len + 4'd1;
                seq[seq_len] = LBR; seq_len = seq_len + 4'd1;
                if (row_bcd[11:8] != 4'd0) begin
                    seq[seq_len] = ASCII_0 | {4'h0, row_bcd[11:8]}; seq_len = seq_len + 4'd1;
                end
                if (row_bcd[11:4] != 8'd0) begin
                    seq[seq_len] = ASCII_0 | {4'h0, row_bcd[7:4]}; seq_len = seq_len + 4'd1;
                end
                seq[seq_len] = ASCII_0 | {4'h0, row_bcd[3:0]}; seq_len = seq_len + 4'd1;
                seq[seq_len] = SEMI; seq_len = seq_len + 4'd1;
                if (col_bcd[11:8] != 4'd0) begin
                    seq[seq_len] = ASCII_0 | {4'h0, col_bcd[11:8]}; seq_len = seq_len + 4'd1;
                end
                if (col_bcd[11:4] != 8'd0) begin
                    seq[seq_len] = ASCII_0 | {4'h0, col_bcd[7:4]}; seq_len = seq_len + 4'd1;
                end
                seq[seq_len] = ASCII_0 | {4'h0, col_bcd[3:0]}; seq_len = seq_len + 4'd1;
                seq[seq_len] = CH_H; seq_len = seq_len + 4'd1;
            end
            StSgr: begin
                seq[0] = ESC; seq[1] = LBR; seq[2] = ASCII_0; seq[3] = SEMI; seq_len = 4'd4;
                if (cell_q[BOLD_BIT]) begin
                    seq[seq_len] = ASCII_0 | 8'd1; seq_len = seq_len + 4'd1;
                    seq[seq_len] = SEMI;           seq_len = seq_len + 4'd1;
                end
                if (cell_q[UL_BIT]) begin
                    seq[seq_len] = ASCII_0 | 8'd4; seq_len = seq_len + 4'd1;
                    seq[seq_len] = SEMI;           seq_len = seq_len + 4'd1;
                end
                seq[seq_len] = ASCII_0 | 8'd3; seq_len = seq_len + 4'd1;
                seq[seq_len] = ASCII_0 | {5'h0, cell_q[FG_MSB:FG_LSB]}; seq_len = seq_len + 4'd1;
                seq[seq_len] = SEMI; seq_len = seq_len + 4'd1;
                seq[seq_len] = ASCII_0 | 8'd4; seq_len = seq_len + 4'd1;
                seq[seq_len] = ASCII_0 | {5'h0, cell_q[BG_MSB:BG_LSB]}; seq_len = seq_len + 4'd1;
                seq[seq_len] = CH_m; seq_len = seq_len + 4'd1;
            end
            StChar: begin
                seq[0]  = (cell_q[7:0] == 8'h00) ? CH_SP : cell_q[7:0];
                seq_len = 4'd1;
            end
            default: ;
        endcase
    end

    // Next-state: byte handshake, frame scan and cache bookkeeping
    always_comb begin
        state_d      = state_q;
        ph_d         = ph_q;
        idx_d        = idx_q;
        addr_d       = addr_q;
        addr_last_d  = addr_last_q;
        cell_d       = cell_q;
        attr_d       = attr_q;
        attr_valid_d = attr_valid_q;
        run_valid_d  = run_valid_q;
        force_act_d  = force_act_q;
        force_pend_d = force_pend_q | SIG_FORCE;
        shadow_we    = 1'b0;
        shadow_re    = 1'b0;
        vram_en      = 1'b0;
        tx_send      = 1'b0;
        emit_done    = 1'b0;
        cnt_load     = 1'b0;
        col_load     = 1'b0;
        col_inc      = 1'b0;
        row_inc      = 1'b0;

        // One gap cycle after every send before TX_READY is looked at again
        if (ph_q == PhGap) begin
            ph_d = PhWait;
        end else if (state_q inside {StHide, StClear, StCup, StSgr, StChar}) begin
            if (ph_q == PhWait && TX_READY) begin
                ph_d = PhSend;
            end else if (ph_q == PhSend) begin
                tx_send = 1'b1;
                ph_d    = PhGap;
                if (idx_q == seq_len - 4'd1) begin
                    idx_d     = 4'd0;
                    emit_done = 1'b1;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
        end

        case (state_q)
            StInit: begin
                addr_d       = '0;
                addr_last_d  = '0;
                attr_d       = 8'h00;
                attr_valid_d = 1'b0;
                run_valid_d  = 1'b0;
                cnt_load     = 1'b1;
                state_d      = StIdle;
            end
            StIdle: begin
                if (SIG_DRAW) begin
                    force_act_d  = force_pend_q;
                    force_pend_d = SIG_FORCE;
                    attr_valid_d = 1'b0;
                    run_valid_d  = 1'b0;
                    addr_d       = '0;
                    cnt_load     = 1'b1;
                    state_d      = StLock;
                end
            end
            StLock:  state_d = StHide;
            StHide:  if (emit_done) state_d = force_act_q ? StClear : StRead;
            StClear: if (emit_done) state_d = StRead;
            StRead: begin
                vram_en   = 1'b1;
                shadow_re = 1'b1;
                state_d   = StLoad;
            end
            StLoad: begin
                cell_d  = VRAM_DATA_R;
                state_d = StCmp;
            end
            StCmp: begin
                if (!force_act_q && (cell_q == shadow_rdata)) begin
                    run_valid_d = 1'b0;
                    state_d     = StNext;
                end else begin
                    state_d = StWshadow;
                end
            end
            StWshadow: begin
                shadow_we = 1'b1;
                if (force_act_q && (cell_q == 16'h0000)) begin
                    run_valid_d = 1'b0;
                    state_d     = StNext;
                end else if (cup_needed) begin
                    state_d = StCup;
                end else begin
                    state_d = sgr_needed ? StSgr : StChar;
                end
            end
            StCup: if (emit_done) state_d = sgr_needed ? StSgr : StChar;
            StSgr: begin
                if (emit_done) begin
                    attr_d       = cell_q[15:8];
                    attr_valid_d = 1'b1;
                    state_d      = StChar;
                end
            end
            StChar: begin
                if (emit_done) begin
                    addr_last_d = addr_q;
                    run_valid_d = 1'b1;
                    state_d     = StNext;
                end
            end
            StNext: begin
                if (addr_q == LastAddr) begin
                    state_d = StDone;
                end else begin
                    addr_d = addr_q + AddrOne;
                    if (addr_q[ColW-1:0] == ColMax) begin
                        col_load = 1'b1;
                        row_inc  = 1'b1;
                    end else begin
                        col_inc = 1'b1;
                    end
                    state_d = StRead;
                end
            end
            StDone: begin
                force_act_d = 1'b0;
                state_d     = StIdle;
            end
            default: state_d = StInit;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= StInit;
            ph_q         <= PhWait;
            idx_q        <= 4'd0;
            addr_q       <= '0;
            addr_last_q  <= '0;
            cell_q       <= 16'h0000;
            attr_q       <= 8'h00;
            attr_valid_q <= 1'b0;
            run_valid_q  <= 1'b0;
            force_pend_q <= 1'b1;
            force_act_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ph_q         <= ph_d;
            idx_q        <= idx_d;
            addr_q       <= addr_d;
            addr_last_q  <= addr_last_d;
            cell_q       <= cell_d;
            attr_q       <= attr_d;
            attr_valid_q <= attr_valid_d;
            run_valid_q  <= run_valid_d;
            force_pend_q <= force_pend_d;
            force_act_q  <= force_act_d;
        end
    end

    // Outputs, forced low while RESET is asserted
    always_comb begin
        vram_lock   = (state_q != StInit) && (state_q != StIdle) && !RESET;
        VRAM_LOCK   = vram_lock;
        SIG_READY   = (state_q == StIdle) && !RESET;
        VRAM_ENABLE = vram_en && !RESET;
        VRAM_ADDR   = vram_lock ? addr_q : '0;
        TX_SEND     = tx_send && !RESET;
        TX_DATA     = (tx_send && !RESET) ? seq[idx_q] : 8'h00;
    end

endmodule

// File: tb/tb_gpu_term_renderer.sv
// Directed bench: two renderers (normal and 3-digit offsets) sharing one VRAM image.
module tb_gpu_term_renderer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic draw_a = 1'b0, draw_b = 1'b0, force_s = 1'b0, tx_stall = 1'b0;
    logic rdy_a = 1'b1, rdy_b = 1'b1;
    logic en_a, lock_a, ready_a, send_a, en_b, lock_b, ready_b, send_b;
    logic [2:0]  addr_a, addr_b;
    logic [7:0]  data_a, data_b;
    logic [15:0] rd_a = 16'h0, rd_b = 16'h0;
    logic [15:0] vram [8];
    logic [7:0]  q_a [$];
    logic [7:0]  q_b [$];
    int hold_a = 0, hold_b = 0, en_cnt_a = 0, last_en_a = -1, bad_en = 0;
    int n_checks = 0, n_errors = 0;
    int cyc;

    localparam string T1   = "~[?25l~[37;40m~[2J";
    localparam string HIDE = "~[?25l";

    always #5 clk = ~clk;

    gpu_term_renderer #(
        .COLS(4), .ROWS(2), .ADDR_W(3), .OFFSET_X(9), .OFFSET_Y(5)
    ) u_dut_a (
        .CLK(clk), .RESET(rst), .VRAM_ENABLE(en_a), .VRAM_ADDR(addr_a), .VRAM_DATA_R(rd_a),
        .VRAM_LOCK(lock_a), .SIG_READY(ready_a), .SIG_DRAW(draw_a), .SIG_FORCE(force_s),
        .TX_DATA(data_a), .TX_SEND(send_a), .TX_READY(rdy_a)
    );

    gpu_term_renderer #(
        .COLS(4), .ROWS(2), .ADDR_W(3), .OFFSET_X(98), .OFFSET_Y(99)
    ) u_dut_b (
        .CLK(clk), .RESET(rst), .VRAM_ENABLE(en_b), .VRAM_ADDR(addr_b), .VRAM_DATA_R(rd_b),
        .VRAM_LOCK(lock_b), .SIG_READY(ready_b), .SIG_DRAW(draw_b), .SIG_FORCE(force_s),
        .TX_DATA(data_b), .TX_SEND(send_b), .TX_READY(rdy_b)
    );

    // Master VRAM: synchronous read ports
    always @(posedge clk) begin
        if (en_a) rd_a <= vram[addr_a];
        if (en_b) rd_b <= vram[addr_b];
    end

    // Transmitter model (ready drops 3 cycles after each byte) and VRAM access monitor
    always @(negedge clk) begin
        if (send_a) begin q_a.push_back(data_a); hold_a = 3; end
        else if (hold_a > 0) hold_a = hold_a - 1;
        if (send_b) begin q_b.push_back(data_b); hold_b = 3; end
        else if (hold_b > 0) hold_b = hold_b - 1;
        rdy_a = (hold_a == 0) && !tx_stall;
        rdy_b = (hold_b == 0) && !tx_stall;
        if (en_a) begin
            last_en_a = int'(addr_a);
            en_cnt_a  = en_cnt_a + 1;
            if (!lock_a) bad_en = bad_en + 1;
        end
        if (en_b && !lock_b) bad_en = bad_en + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks = n_checks + 1;
        if (obs != exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Compare a captured byte stream with an expected string ('~' stands for ESC)
    task automatic check_stream(input string tag, input string exp, input int sel);
        logic [7:0] got [$];
        logic [7:0] e;
        if (sel == 0) begin got = q_a; q_a.delete(); end
        else begin got = q_b; q_b.delete(); end
        check({tag, "_len"}, got.size(), exp.len());
        for (int i = 0; i < exp.len() && i < got.size(); i++) begin
            e = (exp[i] == 8'h7E) ? 8'h1B : exp[i];
            check($sformatf("%s[%0d]", tag, i), int'(got[i]), int'(e));
        end
    endtask

    // Issue SIG_DRAW to the selected DUTs (bit0 = A, bit1 = B) and wait for READY again
    task automatic draw_frame(input logic [1:0] m);
        int c;
        @(negedge clk);
        if (m[0]) check("ready_a_before", int'(ready_a), 1);
        if (m[1]) check("ready_b_before", int'(ready_b), 1);
        draw_a = m[0];
        draw_b = m[1];
        @(negedge clk);
        draw_a = 1'b0;
        draw_b = 1'b0;
        if (m[0]) check("lock_a_rise", int'(lock_a), 1);
        if (m[1]) check("lock_b_rise", int'(lock_b), 1);
        c = 0;
        while (c < 20000 && !((!m[0] || ready_a) && (!m[1] || ready_b))) begin
            @(negedge clk);
            c = c + 1;
        end
        check("frame_end_in_time", int'(c < 20000), 1);
        if (m[0]) check("lock_a_fall", int'(lock_a), 0);
        if (m[1]) check("lock_b_fall", int'(lock_b), 0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) vram[i] = 16'h0000;

        // Reset behaviour
        repeat (3) @(negedge clk);
        check("rst_ready", int'(ready_a), 0);
        check("rst_lock", int'(lock_a), 0);
        check("rst_send", int'(send_a), 0);
        check("rst_en", int'(en_a), 0);
        rst = 1'b0;
        #1 check("init_ready", int'(ready_a), 0);
        @(negedge clk);
        check("idle_ready", int'(ready_a), 1);

        // 1: blank VRAM after reset gives hide + clear only
        en_cnt_a = 0;
        draw_frame(2'b11);
        check_stream("t1a", T1, 0);
        check_stream("t1b", T1, 1);
        check("t1_last_addr", last_en_a, 7);
        check("t1_reads", en_cnt_a, 8);

        // 5: three-digit coordinates on the offset instance
        vram[6] = 16'h3841;
        draw_frame(2'b10);
        check_stream("t5", "~[?25l~[100;100H~[0;37;40mA", 1);
        vram[6] = 16'h0000;

        // 2: latched force, two adjacent cells
        @(negedge clk); force_s = 1'b1;
        @(negedge clk); force_s = 1'b0;
        vram[0] = 16'h3841;
        vram[1] = 16'h3841;
        draw_frame(2'b01);
        check_stream("t2", "~[?25l~[37;40m~[2J~[5;9H~[0;37;40mAA", 0);

        // 3: nothing changed
        en_cnt_a = 0;
        draw_frame(2'b01);
        check_stream("t3", HIDE, 0);
        check("t3_last_addr", last_en_a, 7);
        check("t3_reads", en_cnt_a, 8);

        // 4: attributes, then two separated changes sharing one SGR
        vram[5] = 16'hC942;
        draw_frame(2'b01);
        check_stream("t4a", "~[?25l~[6;10H~[0;1;4;31;41mB", 0);
        vram[5] = 16'hC943;
        vram[7] = 16'hC944;
        draw_frame(2'b01);
        check_stream("t4b", "~[?25l~[6;10H~[0;1;4;31;41mC~[6;12HD", 0);

        // 6: reset while stalled inside a CUP sequence
        vram[2] = 16'h3841;
        @(negedge clk); draw_a = 1'b1;
        @(negedge clk); draw_a = 1'b0;
        cyc = 0;
        while (q_a.size() < 6 && cyc < 2000) begin
            @(posedge clk);
            cyc = cyc + 1;
        end
        tx_stall = 1'b1;
        check("t6_hide_sent", q_a.size(), 6);
        repeat (40) @(negedge clk);
        check("t6_stall_no_send", q_a.size(), 6);
        check("t6_stall_lock", int'(lock_a), 1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_lock", int'(lock_a), 0);
        check("t6_rst_send", int'(send_a), 0);
        rst = 1'b0;
        tx_stall = 1'b0;
        #1 check("t6_init_ready", int'(ready_a), 0);
        @(negedge clk);
        check("t6_idle_ready", int'(ready_a), 1);
        q_a.delete();
        q_b.delete();
        draw_frame(2'b01);
        check_stream("t6", "~[?25l~[37;40m~[2J~[5;9H~[0;37;40mAAA~[6;10H~[0;1;4;31;41mC~[6;12HD",
                     0);

        check("en_outside_lock", bad_en, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/gpu_term_renderer.md
# gpu_term_renderer

Parametrised successor of the serial-terminal GPU. On a draw request it locks the master VRAM and compares every cell against a private shadow copy. For each changed cell it emits ANSI escape sequences and the character to a byte-serial transmitter. It adds three things: configurable geometry with 3-digit coordinates, SGR attribute caching, and cursor-run suppression, so a typical incremental frame sends far fewer bytes.

## Interface
- COLS, 64: cells per row (power of two, 2..256)
- ROWS, 16: rows (power of two, 1..256)
- ADDR_W, 10: VRAM address width, = log2(COLS*ROWS)
- OFFSET_X, 9: terminal column of cell column 0 (1-based, 1..999-COLS+1)
- OFFSET_Y, 5: terminal row of cell row 0 (1-based, 1..999-ROWS+1)
- CLK  in  1  single clock, all logic on rising edge
- RESET  in  1  synchronous, active-high
- VRAM_ENABLE  out  1  master VRAM read strobe
- VRAM_ADDR  out  ADDR_W  master VRAM address, row-major (addr = r*COLS+c)
- VRAM_DATA_R  in  16  read data, valid the cycle after VRAM_ENABLE
- VRAM_LOCK  out  1  held high while the frame scan owns VRAM
- SIG_READY  out  1  idle, accepts SIG_DRAW
- SIG_DRAW  in  1  start a frame (sampled only while SIG_READY)
- SIG_FORCE  in  1  request full redraw on the next frame (level or pulse, latched)
- TX_DATA  out  8  byte to transmit
- TX_SEND  out  1  one-cycle send strobe
- TX_READY  in  1  transmitter can accept a byte

## Operation
- Cell format: [15] bold, [14] underline, [13:11] fg, [10:8] bg, [7:0] ASCII; char 0x00 is sent as 0x20.
- Shadow VRAM: internal ROWS*COLS x 16 synchronous RAM, one-cycle read latency.
- Flags:
  - force_pend: set by RESET and by SIG_FORCE.
  - force_act: loaded from force_pend at frame start; force_pend clears unless SIG_FORCE is high in that same cycle.
- States: INIT → IDLE → LOCK → HIDE → CLEAR → SCAN(READ, LOAD, CMP, WSHADOW, CUP, SGR, CHAR) → NEXT → DONE → IDLE.
- INIT: clear address, caches, lock.
- IDLE: SIG_READY=1; SIG_DRAW → LOCK.
- HIDE: always emit ESC [ ? 2 5 l.
- CLEAR (force_act only): emit ESC [ 3 7 ; 4 0 m ESC [ 2 J.
- Frame start invalidates the attribute cache (attr_valid=0) and the run tracker (run_valid=0).
- Per cell:
  - Read master and shadow.
  - Skip the cell if not force_act and master == shadow.
  - Otherwise write master to shadow.
  - Skip output if force_act and cell == 0x0000 (screen already blank).
- CUP:
  - Omitted when run_valid and the cell is addr_last+1 on the same row.
  - Otherwise emit ESC [ row ; col H, row = OFFSET_Y+r, col = OFFSET_X+c, decimal with leading zeros suppressed (1–3 digits).
- SGR:
  - Omitted when attr_valid and cell[15:8] == attr_cache.
  - Otherwise emit ESC [ 0 ; [1 ;] [4 ;] 3 fg ; 4 bg m, then load attr_cache and set attr_valid.
- CHAR: emit char, set addr_last=addr, run_valid=1.
- Any skipped cell clears run_valid.
- DONE: clear force_act, drop VRAM_LOCK, return to IDLE.
- Row/col positions are tracked with BCD counters, not division.

## Timing
- Output values:
  - During RESET and in INIT: all outputs 0, VRAM_LOCK 0.
  - SIG_READY rises in the second cycle after RESET falls.
- SIG_DRAW accepted in cycle n → VRAM_LOCK high from n+1 until the DONE cycle inclusive, low at DONE+1.
- VRAM_ENABLE only pulses while VRAM_LOCK is high; VRAM_DATA_R is captured one cycle after the pulse.
- TX handshake:
  - TX_SEND is high for exactly one cycle, and only in a cycle following one where TX_READY was sampled 1.
  - TX_DATA is valid with TX_SEND.
  - After each send the block spends ≥1 wait cycle before re-sampling TX_READY.
  - TX_READY held 0 stalls indefinitely, with no byte loss.
- Last cell is addr 2^ADDR_W-1; the address wraps to 0 only through INIT or frame start, never mid-scan.
- SIG_DRAW outside IDLE is ignored.
- SIG_FORCE mid-frame affects the next frame only.
- RESET mid-frame:
  - Next cycle: TX_SEND=0, VRAM_LOCK=0, caches invalid, force_pend=1.
  - Shadow contents are don't-care because the next frame is full.

## Structure
- Package gpu_term_pkg:
  - Cell field positions (BOLD_BIT, UL_BIT, FG_MSB/LSB, BG_MSB/LSB).
  - ANSI constants (ESC=8'h1B, LBR=8'h5B, SEMI=8'h3B, ASCII_0=8'h30, CH_H, CH_m, CH_J, CH_l, CH_Q=8'h3F).
  - State enum.
- Sub-module bcd_counter3: 3-digit BCD counter with synchronous load-of-offset and increment; two instances (row, col) supply the coordinate digits to the FSM.

## Test plan
Tests use COLS=4, ROWS=2, ADDR_W=3, OFFSET_X=9, OFFSET_Y=5, and a TX model whose TX_READY drops for 3 cycles after each send.
1. Reset, VRAM all 0x0000, SIG_DRAW → bytes exactly "ESC[?25l ESC[37;40m ESC[2J"; VRAM_LOCK falls after addr 7; SIG_READY returns.
2. SIG_FORCE, cells 0,1 = 0x3841, SIG_DRAW → "ESC[?25l ESC[37;40m ESC[2J ESC[5;9H ESC[0;37;40m A A".
3. Immediate second SIG_DRAW with no VRAM change → only "ESC[?25l".
4. Cell 5 = 0xC942 → "ESC[?25l ESC[6;10H ESC[0;1;4;31;41m B"; changing cells 5 and 7 (6 unchanged) → two CUPs, one SGR.
5. OFFSET_Y=99, OFFSET_X=98, change cell 6 → "ESC[100;100H…": 3-digit, no leading zeros.
6. RESET asserted during CUP with TX_READY=0 → next cycle VRAM_LOCK=0, TX_SEND=0; the following frame is a full redraw.
